// File: rtl/flag_scan.sv
// rtl/flag_scan.sv - scans NUM_FLAGS consecutive register words and reports which match
// Each word is sampled RD_LATENCY edges after its address is presented.
module flag_scan #(
  parameter int                    WORD_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    NUM_FLAGS   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    RD_LATENCY  = 1,
  parameter logic [WORD_WIDTH-1:0] MATCH_VALUE = {{(WORD_WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                               clock,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               match_mode,
  input  logic [WORD_WIDTH-1:0]              data_in,
  output logic [ADDR_WIDTH-1:0]              address,
  output logic [NUM_FLAGS-1:0]               flags,
  output logic [$clog2(NUM_FLAGS+1)-1:0]     match_count,
  output logic                               any_match,
  output logic                               busy,
  output logic                               done
);

  localparam int CW = $clog2(NUM_FLAGS + 1);
  localparam int IW = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1;
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_FLAGS - 1);
  localparam logic [LW-1:0] LAST_WAIT = LW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [IW-1:0]  index;
  logic [LW-1:0]  wait_cnt;
  logic           mode;
  logic           accept;
  logic           sample;
  logic           last;
  logic           hit;

  always_comb begin
    state_next = IDLE;
    accept     = 1'b0;
    sample     = 1'b0;
    last       = (index == LAST_IDX);
    hit        = mode ? (data_in != '0) : (data_in == MATCH_VALUE);
    case (state)
      IDLE, DONE: begin
        state_next = state;
        if (start) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        state_next = READ;
        // wait_cnt counts edges since the address last moved
        if (wait_cnt == LAST_WAIT) begin
          sample = 1'b1;
          if (last) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      address     <= BASE_ADDR;
      index       <= '0;
      wait_cnt    <= '0;
      mode        <= 1'b0;
      flags       <= '0;
      match_count <= '0;
    end else if (accept) begin
      address     <= BASE_ADDR;
      index       <= '0;
      wait_cnt    <= '0;
      mode        <= match_mode;
      flags       <= '0;
      match_count <= '0;
    end else if (state == READ) begin
      if (sample) begin
        wait_cnt <= '0;
        for (int i = 0; i < NUM_FLAGS; i++) begin
          if (index == IW'(i)) flags[i] <= hit;
        end
        match_count <= match_count + CW'(hit);
        // address stays on the last word once the scan completes
        if (!last) begin
          index   <= index + IW'(1);
          address <= address + ADDR_WIDTH'(1);
        end
      end else begin
        wait_cnt <= wait_cnt + LW'(1);
      end
    end
  end

  assign any_match = |flags;
  assign busy      = (state == READ);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_flag_scan.sv
// tb/tb_flag_scan.sv - bench for flag_scan: default instance and a latency-3 wrapping instance
module tb_flag_scan;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        match_mode = 1'b0;
  logic [15:0] data_a, data_b;
  logic [15:0] addr_a, addr_b;
  logic [3:0]  flags_a, flags_b;
  logic [2:0]  cnt_a, cnt_b;
  logic        any_a, any_b, busy_a, busy_b, done_a, done_b;

  logic [15:0] mem_a [4];
  logic [15:0] mem_b [4];
  logic [15:0] p0, p1, pb_off;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  flag_scan u_a (
    .clock(clock), .rst(rst), .start(start_a), .match_mode(match_mode),
    .data_in(data_a), .address(addr_a), .flags(flags_a), .match_count(cnt_a),
    .any_match(any_a), .busy(busy_a), .done(done_a)
  );

  flag_scan #(
    .NUM_FLAGS(4), .RD_LATENCY(3), .BASE_ADDR(16'hFFFE), .MATCH_VALUE(16'h00A5)
  ) u_b (
    .clock(clock), .rst(rst), .start(start_b), .match_mode(match_mode),
    .data_in(data_b), .address(addr_b), .flags(flags_b), .match_count(cnt_b),
    .any_match(any_b), .busy(busy_b), .done(done_b)
  );

  // latency-1 bank for u_a; a three-edge pipelined bank for u_b
  assign data_a = mem_a[addr_a[1:0]];
  always @(posedge clock) begin
    p0 <= addr_b;
    p1 <= p0;
  end
  assign pb_off = p1 + 16'd2;
  assign data_b = mem_b[pb_off[1:0]];

  typedef struct {
    int          d;
    logic        mode;
    logic [63:0] w;
    logic [3:0]  ef;
    int          ec;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] g_addr(int d);  return d ? 32'(addr_b)  : 32'(addr_a);  endfunction
  function automatic logic [31:0] g_flags(int d); return d ? 32'(flags_b) : 32'(flags_a); endfunction
  function automatic logic [31:0] g_cnt(int d);   return d ? 32'(cnt_b)   : 32'(cnt_a);   endfunction
  function automatic logic [31:0] g_any(int d);   return d ? 32'(any_b)   : 32'(any_a);   endfunction
  function automatic logic [31:0] g_busy(int d);  return d ? 32'(busy_b)  : 32'(busy_a);  endfunction
  function automatic logic [31:0] g_done(int d);  return d ? 32'(done_b)  : 32'(done_a);  endfunction

  // reference: a word matches if nonzero (mode 1) or equal to the instance's match value
  function automatic logic [3:0] model_flags(int d, logic mode, logic [63:0] w);
    logic [3:0]  f;
    logic [15:0] word;
    logic [15:0] mv;
    mv = d ? 16'h00A5 : 16'h0001;
    for (int i = 0; i < 4; i++) begin
      word = w[16*i +: 16];
      f[i] = mode ? (word != 16'd0) : (word == mv);
    end
    return f;
  endfunction

  task automatic scan(input int d, input logic mode, input logic [63:0] w,
                      input logic [3:0] ef, input int ec);
    int          lat;
    int          widx;
    logic [15:0] base;
    logic [15:0] ea;
    lat  = d ? 3 : 1;
    base = d ? 16'hFFFE : 16'h0000;
    for (int i = 0; i < 4; i++) begin
      if (d != 0) mem_b[i] = w[16*i +: 16];
      else        mem_a[i] = w[16*i +: 16];
    end
    match_mode = mode;
    if (d != 0) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
    chk("accept_flags_clear", g_flags(d), 32'd0);
    chk("accept_count_clear", g_cnt(d), 32'd0);
    for (int k = 0; k <= 4 * lat; k++) begin
      if (k > 0) begin
        @(posedge clock);
        @(negedge clock);
      end
      widx = (k / lat > 3) ? 3 : k / lat;
      ea   = base + 16'(widx);
      chk("scan_addr", g_addr(d), 32'(ea));
      chk("scan_busy", g_busy(d), 32'(k < 4 * lat));
      chk("scan_done", g_done(d), 32'(k == 4 * lat));
    end
    chk("scan_flags", g_flags(d), 32'(ef));
    chk("scan_count", g_cnt(d), 32'(ec));
    chk("scan_any", g_any(d), 32'(ef != 4'd0));
  endtask

  initial begin
    logic [63:0] rw;
    logic [15:0] rv;
    logic [3:0]  rf;
    int          rd;
    logic        rm;

    tbl[0] = '{0, 1'b0, {16'd5, 16'd1, 16'd0, 16'd1}, 4'b0101, 2};
    tbl[1] = '{0, 1'b1, {16'd5, 16'd1, 16'd0, 16'd1}, 4'b1101, 3};
    tbl[2] = '{0, 1'b0, 64'd0, 4'b0000, 0};
    tbl[3] = '{0, 1'b1, 64'd0, 4'b0000, 0};
    tbl[4] = '{0, 1'b0, {16'd1, 16'h8001, 16'd1, 16'hFFFF}, 4'b1010, 2};
    tbl[5] = '{1, 1'b0, {16'h00A5, 16'h10A5, 16'h0001, 16'h00A5}, 4'b1001, 2};
    tbl[6] = '{1, 1'b1, {16'd0, 16'd0, 16'd7, 16'd0}, 4'b0010, 1};
    tbl[7] = '{1, 1'b0, {4{16'h00A5}}, 4'b1111, 4};

    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 16'd0;
      mem_b[i] = 16'd0;
    end
    mem_a[0] = 16'd1; mem_a[1] = 16'd0; mem_a[2] = 16'd1; mem_a[3] = 16'd5;

    // reset with start held: reset wins
    start_a = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("rst_addr", g_addr(d), d ? 32'hFFFE : 32'h0);
      chk("rst_flags", g_flags(d), 32'd0);
      chk("rst_count", g_cnt(d), 32'd0);
      chk("rst_any", g_any(d), 32'd0);
      chk("rst_busy", g_busy(d), 32'd0);
      chk("rst_done", g_done(d), 32'd0);
    end
    rst = 1'b0;

    // start held high across a whole scan: ignored while busy, re-accepted from DONE
    @(posedge clock);
    @(negedge clock);
    chk("held_accept_busy", g_busy(0), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk("held_addr", g_addr(0), 32'((k > 3) ? 3 : k));
      chk("held_done", g_done(0), 32'(k == 4));
    end
    chk("held_flags", g_flags(0), 32'h5);
    chk("held_count", g_cnt(0), 32'd2);
    @(posedge clock);
    @(negedge clock);
    chk("reaccept_done", g_done(0), 32'd0);
    chk("reaccept_flags", g_flags(0), 32'd0);
    chk("reaccept_addr", g_addr(0), 32'd0);
    @(posedge clock);
    @(negedge clock);
    chk("partial_flags", g_flags(0), 32'h1);
    rst = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_addr", g_addr(0), 32'd0);
    chk("midrst_flags", g_flags(0), 32'd0);
    chk("midrst_count", g_cnt(0), 32'd0);
    chk("midrst_any", g_any(0), 32'd0);
    chk("midrst_busy", g_busy(0), 32'd0);
    chk("midrst_done", g_done(0), 32'd0);
    rst = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start_a = 1'b0;
    chk("postrst_busy", g_busy(0), 32'd1);
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("postrst_done", g_done(0), 32'd1);
    chk("postrst_flags", g_flags(0), 32'h5);

    for (int i = 0; i < 8; i++) begin
      scan(tbl[i].d, tbl[i].mode, tbl[i].w, tbl[i].ef, tbl[i].ec);
    end

    for (int n = 0; n < 24; n++) begin
      rd = int'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0:       rv = 16'd0;
          1:       rv = (rd != 0) ? 16'h00A5 : 16'h0001;
          2:       rv = 16'($urandom_range(0, 3));
          default: rv = 16'($urandom());
        endcase
        rw[16*i +: 16] = rv;
      end
      rf = model_flags(rd, rm, rw);
      scan(rd, rm, rw, rf, $countones(rf));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
